// File: rtl/iori_anim_ctrl.sv
// Iori sprite animation sequencer: paces frames from frame_clk, loops or one-shots per state.
// Optional macro IORI_ANIM_PAUSE_EN adds a pause input that freezes frame pacing.
module iori_anim_ctrl #(
  parameter int unsigned TICKS_PER_FRAME = 4,
  parameter int unsigned STAND_FRAMES    = 9,
  parameter int unsigned ATTACK_FRAMES   = 6,
  parameter int unsigned FORWARD_FRAMES  = 10,
  parameter int unsigned BACKWARD_FRAMES = 9,
  parameter int unsigned DEFENSE_FRAMES  = 1,
  parameter int unsigned HURT_FRAMES     = 5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_state,
  input  logic       hit,
`ifdef IORI_ANIM_PAUSE_EN
  input  logic       pause,
`endif
  output logic [7:0] character2_state,
  output logic [7:0] frame_num,
  output logic       busy,
  output logic       anim_done
);

  localparam logic [7:0] StStand   = 8'd0;
  localparam logic [7:0] StAttack  = 8'd1;
  localparam logic [7:0] StMoveL   = 8'd2;
  localparam logic [7:0] StMoveR   = 8'd3;
  localparam logic [7:0] StDefense = 8'd4;
  localparam logic [7:0] StHurt    = 8'd5;

  localparam logic [7:0] HoldLast = 8'(TICKS_PER_FRAME - 1);

  function automatic logic [7:0] frame_count(input logic [7:0] st);
    logic [7:0] n;
    case (st)
      StAttack:  n = 8'(ATTACK_FRAMES);
      StMoveL:   n = 8'(FORWARD_FRAMES);
      StMoveR:   n = 8'(BACKWARD_FRAMES);
      StDefense: n = 8'(DEFENSE_FRAMES);
      StHurt:    n = 8'(HURT_FRAMES);
      default:   n = 8'(STAND_FRAMES);
    endcase
    return n;
  endfunction

  logic       fclk_meta_q, fclk_sync_q, fclk_prev_q;
  logic       tick, tick_en;
  logic [7:0] state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       last_frame, oneshot, cmd_accept;

  assign tick = fclk_sync_q & ~fclk_prev_q;
`ifdef IORI_ANIM_PAUSE_EN
  assign tick_en = tick & ~pause;
`else
  assign tick_en = tick;
`endif

  assign last_frame = (frame_q == frame_count(state_q) - 8'd1);
  assign oneshot    = (state_q == StAttack) || (state_q == StHurt);
  // Out-of-range codes, busy lockout and same-state requests are all dropped.
  assign cmd_accept = cmd_valid && (cmd_state <= StHurt) && !busy_q && (cmd_state != state_q);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (hit && state_q != StHurt) begin
      state_d = StHurt;
      frame_d = 8'd0;
      hold_d  = 8'd0;
      busy_d  = 1'b1;
    end else if (cmd_accept) begin
      state_d = cmd_state;
      frame_d = 8'd0;
      hold_d  = 8'd0;
      busy_d  = (cmd_state == StAttack) || (cmd_state == StHurt);
    end else if (tick_en) begin
      if (hold_q == HoldLast) begin
        hold_d = 8'd0;
        if (last_frame && oneshot) begin
          state_d = StStand;
          frame_d = 8'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (last_frame) begin
          frame_d = 8'd0;
        end else begin
          frame_d = frame_q + 8'd1;
        end
      end else begin
        hold_d = hold_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fclk_meta_q <= 1'b0;
      fclk_sync_q <= 1'b0;
      fclk_prev_q <= 1'b0;
      state_q     <= StStand;
      frame_q     <= 8'd0;
      hold_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fclk_meta_q <= frame_clk;
      fclk_sync_q <= fclk_meta_q;
      fclk_prev_q <= fclk_sync_q;
      state_q     <= state_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign character2_state = state_q;
  assign frame_num        = frame_q;
  assign busy             = busy_q;
  assign anim_done        = done_q;

endmodule

// File: doc/iori_anim_ctrl.md
Name: iori_anim_ctrl

Overview:
Animation sequencer for the Iori character sprite ROMs. Produces the registered `character2_state` and `frame_num` that select the sprite ROM and the frame offset. Takes movement and attack commands from the game-logic/keycode layer and hit requests from collision logic. Paces frames from the ~60 Hz frame_clk, enforces one-shot lockout for attack and hurt, and guarantees `frame_num` never exceeds the last frame of the selected ROM.

Parameters:
- TICKS_PER_FRAME, 4: frame_clk rising edges per animation frame. Legal range 1..255.
- STAND_FRAMES, 9: frame count of the stand ROM.
- ATTACK_FRAMES, 6: frame count of the attack ROM.
- FORWARD_FRAMES, 10: frame count of the forward ROM (state_movel).
- BACKWARD_FRAMES, 9: frame count of the backward ROM (state_mover).
- DEFENSE_FRAMES, 1: frame count of the defense ROM.
- HURT_FRAMES, 5: frame count of the hurt ROM.

Ports:
- Clk, input, 1: 50 MHz system clock.
- Reset_n, input, 1: reset, asynchronous, active-low.
- frame_clk, input, 1: vertical-sync-derived frame strobe (~60 Hz), asynchronous to Clk.
- cmd_valid, input, 1: single-cycle command strobe.
- cmd_state, input, 8: requested state. Encoding: 0 stand, 1 attack, 2 movel, 3 mover, 4 defense, 5 hurt.
- hit, input, 1: single-cycle hurt request from collision logic.
- character2_state, output, 8: current animation state, registered.
- frame_num, output, 8: current frame index, registered.
- busy, output, 1: high while an attack or hurt one-shot is in progress.
- anim_done, output, 1: one-Clk pulse when a one-shot completes.

Behaviour:
- **Reset:** character2_state=0, frame_num=0, busy=0, anim_done=0, hold counter=0, synchronizer flops=0.
- **frame_clk tick:** frame_clk passes through a 2-flop synchronizer into a rising-edge detector. The resulting `tick` is one Clk wide and arrives 3 Clk cycles after the frame_clk rise.
- **Hold counter:** 8-bit, increments on each tick. When it equals TICKS_PER_FRAME-1 and a tick occurs, it clears to 0 and the frame advances. Every state change clears the hold counter.
- **LOOP mode** (stand, movel, mover, defense):
  - Frame advance: frame_num+1, wrapping to 0 after N-1, where N is the current state's frame count.
  - With DEFENSE_FRAMES=1, frame_num stays 0.
- **ONESHOT mode** (attack, hurt):
  - Frame advance: frame_num+1.
  - On the advance from frame N-1: next state = stand, frame_num=0, busy=0, and anim_done pulses in the same cycle the state returns to stand.
- **Command acceptance** (cmd_valid=1, takes effect on the next Clk edge):
  - cmd_state>5: ignored.
  - busy=1: all commands ignored, including cmd_state=5.
  - busy=0 and cmd_state equals the current state: ignored; frame_num is not reset.
  - busy=0 and cmd_state differs: state=cmd_state, frame_num=0, hold=0. busy rises if the new state is 1 or 5.
- **hit:** highest priority.
  - Accepted when the current state is not hurt: state=hurt, frame_num=0, hold=0, busy=1. This preempts an attack in progress; anim_done does not pulse for the aborted attack.
  - Ignored while already in hurt.
- **Simultaneous events:**
  - hit and cmd_valid in the same cycle: hit wins, cmd dropped.
  - Command and tick in the same cycle: the command wins; the tick is consumed and does not advance the new state.
  - Final-frame advance and an accepted hit in the same cycle: hit wins, no anim_done.
- **Invariant:** frame_num < frame count of character2_state in every cycle.
- **Reset_n mid-animation:** all outputs return immediately to reset values.

Optional Feature:
IORI_ANIM_PAUSE_EN
- Defined: adds input `pause` (1 bit). While pause=1:
  - ticks are discarded;
  - the hold counter and frame_num freeze;
  - commands and hit are still accepted.
- Not defined: no `pause` port; ticks are always processed.

Test Plan:
1. Reset_n low then released, no commands, TICKS_PER_FRAME=4, 40 frame_clk rises -> stand frames 0..8 wrap: frame_num=(rises/4) mod 9, 1 at rise 4, 0 at rise 36; busy=0 throughout.
2. cmd_state=1 at stand frame 5 -> next cycle state=1, frame_num=0, busy=1. After 24 rises: state=0, frame_num=0, anim_done pulses exactly one Clk, busy=0.
3. During attack frame 3, cmd_state=2 -> ignored. hit -> state=5, frame_num=0, no anim_done. After 20 rises: return to stand with anim_done=1.
4. In movel at frame 7, cmd_state=2 -> frame_num stays 7. cmd_state=3 -> frame_num=0. cmd_state=9 -> no change.
5. hit and cmd_valid (cmd_state=4) in the same cycle -> state=5. Second hit during hurt -> ignored, frame sequence continues uninterrupted.
6. Reset_n asserted asynchronously at hurt frame 2 (mid-cycle) -> outputs 0 before the next Clk edge. With IORI_ANIM_PAUSE_EN and pause=1 for 10 rises -> frame_num unchanged.
